roteamento_arbitro: RTL and testbench
=====================================

ROTEAMENTO_ARBITRO -- requirements
Module: roteamento_arbitro

Interface
REQ-001 Parameter MAX_RAJADA, default 4, max transfers per grant before forced release (legal 1..15).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request per source; bit0=A, bit1=B, bit2=C, bit3=D.
REQ-005 A, B, C, D  input  4 each  source data words.
REQ-006 pronto  input  1  consumer ready; transfer occurs when valido and pronto both high.
REQ-007 SEL  output  2  registered index of granted source (00=A, 01=B, 10=C, 11=D).
REQ-008 gnt  output  4  registered one-hot grant, all-zero when no grant.
REQ-009 valido  output  1  data valid: high iff state ATIVO and req[SEL] high (combinational).
REQ-010 Saida  output  4  source selected by SEL when valido high, else 4'b0000.

Function
REQ-011 FSM states IDLE and ATIVO; IDLE on reset.
REQ-012 IDLE, req==0: stay IDLE, gnt=0000, SEL held.
REQ-013 IDLE, req!=0: winner = first set bit scanning from ptr upward, wrapping 3->0; next edge: ATIVO, gnt=one-hot(winner), SEL=winner, contador=0.
REQ-014 Arbitration latency: exactly 1 cycle from req sampled in IDLE to gnt high.
REQ-015 ATIVO: transfer = valido & pronto; each transfer increments contador (4-bit).
REQ-016 ATIVO, req[SEL] low at an edge: release -> IDLE, gnt=0000, no transfer that cycle.
REQ-017 ATIVO, transfer with contador==MAX_RAJADA-1: that transfer completes, then release -> IDLE.
REQ-018 On every release, ptr <= SEL+1 mod 4 (round-robin rotation).
REQ-019 IDLE bubble of exactly one cycle between consecutive grants; valido low in that cycle.
REQ-020 Requests from non-granted sources during ATIVO are ignored until next IDLE arbitration.
REQ-021 pronto low in ATIVO: hold grant, no count, valido/Saida stable while req[SEL] high.
REQ-022 req[SEL] and transfer-limit in same cycle: req drop wins (no transfer counted), release.
REQ-023 Data inputs are not registered; Saida follows A..D in the same cycle.

Reset
REQ-024 reset high forces immediately (asynchronously): state=IDLE, gnt=0000, SEL=00, ptr=00, contador=0, hence valido=0, Saida=0000.
REQ-025 reset asserted mid-burst aborts the grant; no transfer is counted in that cycle; after deassertion arbitration restarts from ptr=00.

Configuration
REQ-026 Macro ROTEAMENTO_PRIORIDADE_FIXA_EN defined: winner = lowest-index set req bit (A highest), ptr unused; MAX_RAJADA limit and bubble still apply.
REQ-027 Macro not defined: round-robin per REQ-013/REQ-018.

Verification
REQ-028 Reset then req=0001, A=4'hA, pronto=1: gnt=0001 one cycle later, SEL=00, valido=1, Saida=4'hA.
REQ-029 req=1111 held, pronto=1, MAX_RAJADA=4: grants A,B,C,D in order, each 4 transfers, one idle cycle between, then A again.
REQ-030 Grant to C, pronto=0 three cycles then 1: Saida=C stable, contador unchanged until pronto=1; req[2] dropped -> gnt=0000 next edge, ptr=11.
REQ-031 reset pulsed mid-burst of B (contador=2): gnt=0000, Saida=0000 without clock edge; after release, req=1010 -> B granted.
REQ-032 With ROTEAMENTO_PRIORIDADE_FIXA_EN, req=1111 held: A re-granted every burst (4 transfers, 1 bubble); B never granted.

Source files
------------

// File: rtl/roteamento_arbitro.sv
// roteamento_arbitro: four-source burst arbiter with a registered grant and a
// combinational data path.
// The default build rotates priority round-robin after every release.
// Defining ROTEAMENTO_PRIORIDADE_FIXA_EN switches to fixed priority, with A
// highest. The MAX_RAJADA burst limit and the one-cycle IDLE bubble apply in
// both builds.
module roteamento_arbitro #(
  parameter int unsigned MAX_RAJADA = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic       pronto,
  output logic [1:0] SEL,
  output logic [3:0] gnt,
  output logic       valido,
  output logic [3:0] Saida
);

  localparam int unsigned NUM_FONTES = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned CNT_W      = 4;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(MAX_RAJADA - 1);

  typedef enum logic {IDLE, ATIVO} estado_t;

  estado_t          estado_q, estado_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] vencedor;
  logic             liberar;
  logic             transfer;

`ifdef ROTEAMENTO_PRIORIDADE_FIXA_EN
  // Fixed priority: lowest-index requester wins.
  always_comb begin
    vencedor = '0;
    for (int i = NUM_FONTES - 1; i >= 0; i--) begin
      if (req[i]) vencedor = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] rr_idx;
  logic             achou;

  // Round-robin: first requester found scanning upward from ptr, wrapping.
  always_comb begin
    vencedor = ptr_q;
    rr_idx   = ptr_q;
    achou    = 1'b0;
    for (int i = 0; i < NUM_FONTES; i++) begin
      rr_idx = ptr_q + IDX_W'(i);
      if (!achou && req[rr_idx]) begin
        vencedor = rr_idx;
        achou    = 1'b1;
      end
    end
  end

  // Rotate the pointer past the source that just released.
  always_comb begin
    ptr_d = ptr_q;
    if (liberar) ptr_d = sel_q + IDX_W'(1);
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  // A transfer happens only while the granted source still requests.
  assign valido   = (estado_q == ATIVO) && req[sel_q];
  assign transfer = valido && pronto;

  // Next-state logic: grant in IDLE, count and release in ATIVO.
  always_comb begin
    estado_d = estado_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    liberar  = 1'b0;
    case (estado_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          estado_d = ATIVO;
          sel_d    = vencedor;
          gnt_d    = 4'b0001 << vencedor;
          cnt_d    = '0;
        end
      end
      ATIVO: begin
        // A dropped request takes precedence over the burst limit.
        if (!req[sel_q]) begin
          liberar = 1'b1;
        end else if (transfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == ULTIMO) liberar = 1'b1;
        end
      end
      default: estado_d = IDLE;
    endcase
    if (liberar) begin
      estado_d = IDLE;
      gnt_d    = '0;
    end
  end

  // State, grant, select and burst counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      sel_q    <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
    end
  end

  // Unregistered data mux, forced to zero when nothing is valid.
  always_comb begin
    Saida = '0;
    if (valido) begin
      case (sel_q)
        2'd0:    Saida = A;
        2'd1:    Saida = B;
        2'd2:    Saida = C;
        default: Saida = D;
      endcase
    end
  end

  assign SEL = sel_q;
  assign gnt = gnt_q;

endmodule

// File: tb/tb_roteamento_arbitro.sv
// Testbench for roteamento_arbitro.
// An owner/count reference model is checked against the DUT on every falling
// edge. Directed scenarios add hand-computed literal checks on top of that.
module tb_roteamento_arbitro;

  localparam int MAXR = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] A = '0, B = '0, C = '0, D = '0;
  logic       pronto = 1'b0;
  logic [1:0] SEL;
  logic [3:0] gnt;
  logic       valido;
  logic [3:0] Saida;

  int total = 0;
  int bad   = 0;

  roteamento_arbitro #(.MAX_RAJADA(MAXR)) dut (
    .clk(clk), .reset(reset), .req(req),
    .A(A), .B(B), .C(C), .D(D), .pronto(pronto),
    .SEL(SEL), .gnt(gnt), .valido(valido), .Saida(Saida)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
    end
  endtask

  // Reference model: owner is the granted source, or -1 when none is granted.
  int owner = -1;
  int m_sel = 0;
  int m_cnt = 0;
  int m_ptr = 0;

  function automatic int escolhe(input logic [3:0] r, input int p);
    int base;
`ifdef ROTEAMENTO_PRIORIDADE_FIXA_EN
    base = 0;
`else
    base = p;
`endif
    for (int i = 0; i < 4; i++) begin
      if (r[(base + i) % 4]) return (base + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] dado(input int s);
    case (s)
      0:       return A;
      1:       return B;
      2:       return C;
      default: return D;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      owner = -1; m_sel = 0; m_cnt = 0; m_ptr = 0;
    end else if (owner < 0) begin
      if (req != 4'b0000) begin
        owner = escolhe(req, m_ptr);
        m_sel = owner;
        m_cnt = 0;
      end
    end else if (!req[m_sel]) begin
      m_ptr = (m_sel + 1) % 4;
      owner = -1;
    end else if (pronto) begin
      m_cnt++;
      if (m_cnt == MAXR) begin
        m_ptr = (m_sel + 1) % 4;
        owner = -1;
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic       v_e;
    logic [3:0] g_e;
    v_e = (owner >= 0) && req[m_sel];
    g_e = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(g_e));
    chk("SEL", 32'(SEL), 32'(m_sel));
    chk("valido", 32'(valido), 32'(v_e));
    chk("Saida", 32'(Saida), v_e ? 32'(dado(m_sel)) : 32'd0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0; pronto = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] e;
    #1;
    do_reset();
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset SEL", 32'(SEL), 32'h0);
    chk("reset valido", 32'(valido), 32'h0);
    chk("reset Saida", 32'(Saida), 32'h0);

    // Single request from A: granted after exactly one edge.
    A = 4'hA; B = 4'hB; C = 4'hC; D = 4'hD;
    req = 4'b0001; pronto = 1'b1;
    step(1);
    chk("a gnt", 32'(gnt), 32'h1);
    chk("a SEL", 32'(SEL), 32'h0);
    chk("a valido", 32'(valido), 32'h1);
    chk("a Saida", 32'(Saida), 32'hA);

    // All sources requesting: four-transfer bursts separated by one bubble.
    do_reset();
    req = 4'b1111; pronto = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step(1);
      if ((k - 1) % 5 == 4) e = 4'b0000;
`ifdef ROTEAMENTO_PRIORIDADE_FIXA_EN
      else e = 4'b0001;
`else
      else e = 4'b0001 << (((k - 1) / 5) % 4);
`endif
      chk("burst gnt", 32'(gnt), 32'(e));
    end

    // Grant C, stall three cycles, resume, then drop the request.
    do_reset();
    C = 4'h5; req = 4'b0100; pronto = 1'b0;
    step(1);
    chk("c gnt", 32'(gnt), 32'h4);
    chk("c Saida", 32'(Saida), 32'h5);
    step(2);
    chk("c stall gnt", 32'(gnt), 32'h4);
    chk("c stall Saida", 32'(Saida), 32'h5);
    C = 4'h9;
    #1;
    chk("c follows data", 32'(Saida), 32'h9);
    pronto = 1'b1;
    step(2);
    chk("c after 2 xfers", 32'(gnt), 32'h4);
    req = 4'b0000;
    step(1);
    chk("c drop gnt", 32'(gnt), 32'h0);
    chk("c drop valido", 32'(valido), 32'h0);
    req = 4'b1111;
    step(1);
`ifdef ROTEAMENTO_PRIORIDADE_FIXA_EN
    chk("after c", 32'(gnt), 32'h1);
`else
    chk("after c ptr=3", 32'(gnt), 32'h8);
`endif

    // Reset pulsed mid-burst of B, then arbitration restarts from A.
    do_reset();
    req = 4'b0010; pronto = 1'b1;
    step(1);
    chk("b gnt", 32'(gnt), 32'h2);
    step(2);
    chk("b mid gnt", 32'(gnt), 32'h2);
    reset = 1'b1;
    #1;
    chk("async gnt", 32'(gnt), 32'h0);
    chk("async Saida", 32'(Saida), 32'h0);
    chk("async valido", 32'(valido), 32'h0);
    reset = 1'b0;
    req = 4'b1010;
    step(1);
    chk("b regrant", 32'(gnt), 32'h2);
    chk("b regrant SEL", 32'(SEL), 32'h1);
    req = 4'b0000;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
